counter_sequencer: RTL and testbench

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_sequencer_if.sv | 31 +++
 rtl/counter_sequencer.sv | 162 ++++++++++++++++
 tb/tb_counter_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_sequencer_if.sv
// Command handshake bundle for counter_sequencer.
// The master offers commands, and the sequencer (slave) returns cmd_ready.
interface counter_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [3:0]  cmd_repeat;
  logic        cmd_serial_bit;
  logic        cmd_abort;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    output cmd_repeat,
    output cmd_serial_bit,
    output cmd_abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    input  cmd_repeat,
    input  cmd_serial_bit,
    input  cmd_abort,
    output cmd_ready
  );
endinterface

// File: rtl/counter_sequencer.sv
// Two-state command sequencer that drives one-cycle strobes into a downstream counter.
// Defining SEQ_SERIAL_STREAM_EN streams cmd_data bits into the shift-in lines.
module counter_sequencer (
  input  logic                       i_clk,
  input  logic                       i_rst,
  counter_sequencer_if.slave         cmd,
  output logic [15:0]                o_counter_in_data,
  output logic                       o_counter_in_msb,
  output logic                       o_counter_in_lsb,
  output logic                       o_do_reset,
  output logic                       o_do_load,
  output logic                       o_do_increment,
  output logic                       o_do_decrement,
  output logic                       o_do_shift_l2r,
  output logic                       o_do_shift_r2l,
  output logic                       o_done,
  output logic                       o_err_flag
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_RST = 3'd1;
  localparam logic [2:0] OP_LD  = 3'd2;
  localparam logic [2:0] OP_INC = 3'd3;
  localparam logic [2:0] OP_DEC = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;

  logic [0:0]  r_state;
  logic [3:0]  r_cnt;
  logic [5:0]  r_strobe;
  logic [15:0] r_data;
  logic        r_done;
  logic        r_err;

  logic        w_ready;
  logic        w_accept;
  logic        w_last;
  logic        w_rpt_op;
  logic [5:0]  w_strobe;
  logic        w_sb;

  assign w_ready  = (r_state == S_IDLE);
  assign w_accept = cmd.cmd_valid & w_ready;
  assign w_last   = (r_cnt == 4'd0) | cmd.cmd_abort;

  always_comb begin
    w_strobe = 6'b000000;
    w_rpt_op = 1'b0;
    case (cmd.cmd_op)
      OP_RST:  w_strobe = 6'b000001;
      OP_LD:   w_strobe = 6'b000010;
      OP_INC: begin
        w_strobe = 6'b000100;
        w_rpt_op = 1'b1;
      end
      OP_DEC: begin
        w_strobe = 6'b001000;
        w_rpt_op = 1'b1;
      end
      OP_SHR: begin
        w_strobe = 6'b010000;
        w_rpt_op = 1'b1;
      end
      OP_SHL: begin
        w_strobe = 6'b100000;
        w_rpt_op = 1'b1;
      end
      default: w_strobe = 6'b000000;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_strobe <= 6'b000000;
      r_data   <= 16'h0000;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_data <= cmd.cmd_data;
            r_cnt  <= w_rpt_op ? cmd.cmd_repeat : 4'd0;
            if (cmd.cmd_op == OP_RSV) begin
              r_err <= 1'b1;
            end
            // NOP and reserved retire straight from IDLE
            if (cmd.cmd_op == OP_NOP || cmd.cmd_op == OP_RSV) begin
              r_done <= 1'b1;
            end else begin
              r_state  <= S_EXEC;
              r_strobe <= w_strobe;
            end
          end
        end
        S_EXEC: begin
          if (w_last) begin
            r_state  <= S_IDLE;
            r_strobe <= 6'b000000;
            r_cnt    <= 4'd0;
            r_done   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_strobe <= 6'b000000;
        end
      endcase
    end
  end

`ifdef SEQ_SERIAL_STREAM_EN
  logic [3:0] r_idx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx <= 4'd0;
    end else if (w_accept) begin
      r_idx <= 4'd0;
    end else if (r_state == S_EXEC && !w_last) begin
      r_idx <= r_idx + 4'd1;
    end
  end

  assign w_sb = r_data[r_idx];
`else
  logic r_serial;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_serial <= 1'b0;
    end else if (w_accept) begin
      r_serial <= cmd.cmd_serial_bit;
    end
  end

  assign w_sb = r_serial;
`endif

  assign cmd.cmd_ready      = w_ready;
  assign o_counter_in_data  = r_data;
  assign o_counter_in_msb   = w_sb;
  assign o_counter_in_lsb   = w_sb;
  assign o_do_reset         = r_strobe[0];
  assign o_do_load          = r_strobe[1];
  assign o_do_increment     = r_strobe[2];
  assign o_do_decrement     = r_strobe[3];
  assign o_do_shift_l2r     = r_strobe[4];
  assign o_do_shift_r2l     = r_strobe[5];
  assign o_done             = r_done;
  assign o_err_flag         = r_err;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer.
// Expected strobe/done events are queued per command and popped by a monitor.
module tb_counter_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  counter_sequencer_if cmd();

  logic [15:0] o_counter_in_data;
  logic        o_counter_in_msb;
  logic        o_counter_in_lsb;
  logic        o_do_reset;
  logic        o_do_load;
  logic        o_do_increment;
  logic        o_do_decrement;
  logic        o_do_shift_l2r;
  logic        o_do_shift_r2l;
  logic        o_done;
  logic        o_err_flag;

  counter_sequencer dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .cmd               (cmd.slave),
    .o_counter_in_data (o_counter_in_data),
    .o_counter_in_msb  (o_counter_in_msb),
    .o_counter_in_lsb  (o_counter_in_lsb),
    .o_do_reset        (o_do_reset),
    .o_do_load         (o_do_load),
    .o_do_increment    (o_do_increment),
    .o_do_decrement    (o_do_decrement),
    .o_do_shift_l2r    (o_do_shift_l2r),
    .o_do_shift_r2l    (o_do_shift_r2l),
    .o_done            (o_done),
    .o_err_flag        (o_err_flag)
  );

  logic [5:0] w_stb;
  assign w_stb = {o_do_shift_r2l, o_do_shift_l2r, o_do_decrement,
                  o_do_increment, o_do_load, o_do_reset};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [5:0]  stb;
    logic        sb;
    logic        done;
    logic        chk_sb;
    logic [15:0] data;
  } ev_t;

  ev_t sbq[$];
  ev_t mon_e;

  function automatic logic exp_sb(input logic [15:0] d, input logic s,
                                  input int i);
`ifdef SEQ_SERIAL_STREAM_EN
    return d[i];
`else
    return s;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst && ((|w_stb) || o_done)) begin
      check("onehot", 32'($onehot0(w_stb)), 32'd1);
      if (sbq.size() == 0) begin
        check("unexp_ev", {25'd0, w_stb, o_done}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("stb", 32'(w_stb), 32'(mon_e.stb));
        check("done", 32'(o_done), 32'(mon_e.done));
        check("data", 32'(o_counter_in_data), 32'(mon_e.data));
        if (mon_e.chk_sb) begin
          check("msb", 32'(o_counter_in_msb), 32'(mon_e.sb));
          check("lsb", 32'(o_counter_in_lsb), 32'(mon_e.sb));
        end
      end
    end
  end

  // abort_at: -1 never, -2 raised only on the accept cycle, else strobe index
  task automatic issue(input logic [2:0] op, input logic [15:0] d,
                       input logic [3:0] rpt, input logic sb,
                       input int abort_at);
    int  n;
    bit  seen;
    ev_t e;
    if (op == 3'd1 || op == 3'd2) n = 1;
    else if (op >= 3'd3 && op <= 3'd6) n = int'(rpt) + 1;
    else n = 0;
    if (abort_at >= 0 && abort_at < n) n = abort_at + 1;
    for (int i = 0; i < n; i++) begin
      e.stb    = 6'b000001 << (op - 3'd1);
      e.sb     = exp_sb(d, sb, i);
      e.done   = 1'b0;
      e.chk_sb = 1'b1;
      e.data   = d;
      sbq.push_back(e);
    end
    e.stb    = 6'b000000;
    e.sb     = 1'b0;
    e.done   = 1'b1;
    e.chk_sb = 1'b0;
    e.data   = d;
    sbq.push_back(e);
    check("rdy_idle", 32'(cmd.cmd_ready), 32'd1);
    cmd.cmd_valid      = 1'b1;
    cmd.cmd_op         = op;
    cmd.cmd_data       = d;
    cmd.cmd_repeat     = rpt;
    cmd.cmd_serial_bit = sb;
    cmd.cmd_abort      = (abort_at == -2);
    @(posedge clk);
    #1;
    cmd.cmd_valid  = 1'b0;
    cmd.cmd_op     = 3'd0;
    cmd.cmd_data   = 16'h0000;
    cmd.cmd_repeat = 4'd0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cmd.cmd_abort = (k == abort_at);
      @(negedge clk);
      if (o_done) begin
        seen = 1'b1;
        check("latency", 32'(k), 32'(n));
        check("rdy_done", 32'(cmd.cmd_ready), 32'd1);
      end else begin
        check("rdy_busy", 32'(cmd.cmd_ready), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    cmd.cmd_abort = 1'b0;
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    check("q_empty", 32'(sbq.size()), 32'd0);
    check("cid_hold", 32'(o_counter_in_data), 32'(d));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stb"}, 32'(w_stb), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_err"}, 32'(o_err_flag), 32'd0);
    check({tag, "_data"}, 32'(o_counter_in_data), 32'd0);
    check({tag, "_msb"}, 32'(o_counter_in_msb), 32'd0);
    check({tag, "_lsb"}, 32'(o_counter_in_lsb), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    ev_t e;
    logic [2:0]  rop;
    logic [15:0] rd;
    logic [3:0]  rr;
    logic        rs;
    cmd.cmd_valid      = 1'b0;
    cmd.cmd_op         = 3'd0;
    cmd.cmd_data       = 16'h0000;
    cmd.cmd_repeat     = 4'd0;
    cmd.cmd_serial_bit = 1'b0;
    cmd.cmd_abort      = 1'b0;
    #12;
    check_zero("rst");
    check("rst_rdy", 32'(cmd.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(3'd2, 16'hA5C3, 4'd7, 1'b0, -1);
    issue(3'd3, 16'h1234, 4'd15, 1'b0, -1);
    issue(3'd5, 16'h0005, 4'd3, 1'b1, -1);
    issue(3'd6, 16'hF0F0, 4'd0, 1'b0, -1);
    issue(3'd4, 16'h0BEE, 4'd9, 1'b1, 2);
    issue(3'd3, 16'h00FF, 4'd2, 1'b0, -2);
    issue(3'd1, 16'h7777, 4'd5, 1'b1, -1);
    issue(3'd0, 16'hCAFE, 4'd3, 1'b0, -1);
    check("err_clear", 32'(o_err_flag), 32'd0);
    issue(3'd7, 16'hBAD0, 4'd4, 1'b1, -1);
    check("err_set", 32'(o_err_flag), 32'd1);
    issue(3'd4, 16'h5555, 4'd1, 1'b0, -1);
    check("err_sticky", 32'(o_err_flag), 32'd1);

    for (int j = 0; j < 6; j++) begin
      rop = 3'($urandom_range(1, 6));
      rd  = 16'($urandom);
      rr  = 4'($urandom_range(0, 15));
      rs  = 1'($urandom);
      issue(rop, rd, rr, rs, -1);
    end

    // reset during the 2nd of 5 shift-right-to-left strobes
    e.stb    = 6'b100000;
    e.sb     = exp_sb(16'h3C3C, 1'b1, 0);
    e.done   = 1'b0;
    e.chk_sb = 1'b1;
    e.data   = 16'h3C3C;
    sbq.push_back(e);
    cmd.cmd_valid      = 1'b1;
    cmd.cmd_op         = 3'd6;
    cmd.cmd_data       = 16'h3C3C;
    cmd.cmd_repeat     = 4'd4;
    cmd.cmd_serial_bit = 1'b1;
    @(posedge clk);
    #1;
    cmd.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_stb", 32'(w_stb), 32'h20);
    #2;
    rst = 1'b1;
    #1;
    check_zero("arst");
    check("arst_q", 32'(sbq.size()), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_done", 32'(o_done), 32'd0);
      check("post_rdy", 32'(cmd.cmd_ready), 32'd1);
      check("post_stb", 32'(w_stb), 32'd0);
    end
    @(posedge clk);
    #1;
    issue(3'd2, 16'h0F1E, 4'd3, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
